// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game sequencer.
//   state_t    : game phase encoding, also driven out on the state port
//   BLANK      : BCD code the display driver renders as an unlit digit
//   LFSR_SEED  : nonzero reset value of the delay LFSR
//   LFSR_TAPS  : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
package reaction_pkg;

  typedef enum logic [1:0] {
    StStart  = 2'd0,
    StReady  = 2'd1,
    StPlay   = 2'd2,
    StFinish = 2'd3
  } state_t;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_bcd_counter2.sv
// Two-digit BCD up-counter, saturating at 99.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : synchronous clear to 00 (wins over inc_i)
//   inc_i         : add one; ignored while at_max_o is set
//   tens_o/ones_o : BCD digits
//   at_max_o      : count is 99
module bcd_counter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       at_max_o
);

  logic [3:0] tens_q, ones_q;

  assign at_max_o = (tens_q == 4'd9) && (ones_q == 4'd9);
  assign tens_o   = tens_q;
  assign ones_o   = ones_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (clr_i) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (inc_i && !at_max_o) begin
      if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: arm -> random wait -> timed play -> result hold.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   tick_i          : one-cycle 0.1 s strobe
//   arm_i           : high requests a game, low aborts / returns to START
//   btn_i           : player button level (already synchronous)
//   tens_o, ones_o  : BCD digits for the display, 4'hF is blank
//   state_o         : current phase (START/READY/PLAY/FINISH)
//   false_start_o   : button was pressed during READY
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned MIN_DELAY = 10,
  parameter int unsigned RAND_W    = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       arm_i,
  input  logic       btn_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic [1:0] state_o,
  output logic       false_start_o
);

  // Mask is zero when RAND_W == 0, giving a fixed MIN_DELAY wait.
  localparam logic [7:0] RandMask = 8'((1 << RAND_W) - 1);
  localparam logic [7:0] MinDelay = 8'(MIN_DELAY);

  state_t     state_q;
  logic [7:0] delay_q;
  logic [7:0] lfsr_q;
  logic       btn_q;
  logic       fs_q;
  logic       blank_q;  // display shows blanks
  logic       nines_q;  // display forced to 99 (false start)

  logic       press;
  logic       cnt_clr, cnt_inc, cnt_max;
  logic [3:0] cnt_tens, cnt_ones;

  assign press = btn_i & ~btn_q;

  // Counter sits at 00 until PLAY; press beats tick so the count freezes on that edge.
  assign cnt_clr = (state_q == StStart) || (state_q == StReady);
  assign cnt_inc = (state_q == StPlay) && arm_i && tick_i && !press;

  bcd_counter2 u_count (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .tens_o   (cnt_tens),
    .ones_o   (cnt_ones),
    .at_max_o (cnt_max)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StStart;
      delay_q <= 8'd0;
      lfsr_q  <= LFSR_SEED;
      btn_q   <= 1'b0;
      fs_q    <= 1'b0;
      blank_q <= 1'b1;
      nines_q <= 1'b0;
    end else begin
      btn_q  <= btn_i;
      lfsr_q <= lfsr_next(lfsr_q);
      unique case (state_q)
        StStart: begin
          blank_q <= 1'b1;
          nines_q <= 1'b0;
          fs_q    <= 1'b0;
          if (arm_i) begin
            delay_q <= MinDelay + (lfsr_q & RandMask);
            state_q <= StReady;
          end
        end
        StReady: begin
          if (!arm_i) begin
            state_q <= StStart;
          end else if (press) begin
            state_q <= StFinish;
            fs_q    <= 1'b1;
            nines_q <= 1'b1;
            blank_q <= 1'b0;
          end else if (tick_i) begin
            if (delay_q <= 8'd1) begin
              state_q <= StPlay;
              blank_q <= 1'b0;
            end else begin
              delay_q <= delay_q - 8'd1;
            end
          end
        end
        StPlay: begin
          if (!arm_i) begin
            state_q <= StStart;
            blank_q <= 1'b1;
          end else if (press || (tick_i && cnt_max)) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          if (!arm_i) begin
            state_q <= StStart;
            blank_q <= 1'b1;
            nines_q <= 1'b0;
            fs_q    <= 1'b0;
          end
        end
        default: state_q <= StStart;
      endcase
    end
  end

  // Pure decode of registered flags and counter registers; no input paths.
  always_comb begin
    tens_o = cnt_tens;
    ones_o = cnt_ones;
    if (blank_q) begin
      tens_o = BLANK;
      ones_o = BLANK;
    end else if (nines_q) begin
      tens_o = 4'd9;
      ones_o = 4'd9;
    end
  end

  assign state_o       = state_q;
  assign false_start_o = fs_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
module tb_reaction_game_ctrl;

  typedef struct {
    logic       tick;
    logic       btn;
    logic       arm;
    int         rep;
    logic [1:0] st;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       fs;
    string      name;
  } vec_t;

  localparam logic [3:0] B = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, arm = 1'b0, btn = 1'b0;
  logic [3:0] tens, ones;
  logic [1:0] state;
  logic       fs;

  logic       tick2 = 1'b0, arm2 = 1'b0, btn2 = 1'b0;
  logic [3:0] tens2, ones2;
  logic [1:0] state2;
  logic       fs2;

  logic [7:0] m_lfsr;
  int         total = 0;
  int         bad = 0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  reaction_game_ctrl #(.MIN_DELAY(10), .RAND_W(0)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick),
    .arm_i         (arm),
    .btn_i         (btn),
    .tens_o        (tens),
    .ones_o        (ones),
    .state_o       (state),
    .false_start_o (fs)
  );

  reaction_game_ctrl #(.MIN_DELAY(2), .RAND_W(3)) dut_rand (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick2),
    .arm_i         (arm2),
    .btn_i         (btn2),
    .tens_o        (tens2),
    .ones_o        (ones2),
    .state_o       (state2),
    .false_start_o (fs2)
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 01, steps every cycle out of reset.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic cyc(input logic t, input logic b, input logic a);
    tick = t;
    btn  = b;
    arm  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] st, input logic [3:0] te,
                     input logic [3:0] on, input logic f);
    total++;
    if ({state, tens, ones, fs} !== {st, te, on, f}) begin
      bad++;
      $display("FAIL %s: got state=%0d digits=%h%h fs=%b, want state=%0d digits=%h%h fs=%b",
               name, state, tens, ones, fs, st, te, on, f);
    end
  endtask

  task automatic add(input logic t, input logic b, input logic a, input int rep,
                     input logic [1:0] st, input logic [3:0] te, input logic [3:0] on,
                     input logic f, input string name);
    vec_t v;
    v.tick = t; v.btn = b; v.arm = a; v.rep = rep;
    v.st = st; v.tens = te; v.ones = on; v.fs = f; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    // Normal game
    add(0, 0, 0, 3,  0, B, B, 0, "idle_after_reset");
    add(0, 0, 1, 1,  1, B, B, 0, "arm");
    add(1, 0, 1, 9,  1, B, B, 0, "ready_9_ticks");
    add(1, 0, 1, 1,  2, 0, 0, 0, "play_00");
    add(0, 0, 1, 1,  2, 0, 0, 0, "play_no_tick");
    add(1, 0, 1, 37, 2, 3, 7, 0, "count_37");
    add(0, 1, 1, 1,  3, 3, 7, 0, "press_37");
    add(1, 1, 1, 5,  3, 3, 7, 0, "finish_hold");
    add(0, 0, 0, 1,  0, B, B, 0, "disarm");
    // False start
    add(0, 0, 1, 1,  1, B, B, 0, "fs_arm");
    add(1, 0, 1, 4,  1, B, B, 0, "fs_4_ticks");
    add(0, 1, 1, 1,  3, 9, 9, 1, "false_start");
    add(1, 0, 1, 3,  3, 9, 9, 1, "fs_hold");
    add(0, 0, 0, 1,  0, B, B, 0, "fs_clear");
    // Timeout
    add(0, 0, 1, 1,  1, B, B, 0, "to_arm");
    add(1, 0, 1, 10, 2, 0, 0, 0, "to_play");
    add(1, 0, 1, 99, 2, 9, 9, 0, "count_99");
    add(1, 0, 1, 1,  3, 9, 9, 0, "timeout");
    add(1, 0, 1, 5,  3, 9, 9, 0, "timeout_hold");
    add(0, 0, 0, 1,  0, B, B, 0, "to_disarm");
    // Tick and press together in PLAY
    add(0, 0, 1, 1,  1, B, B, 0, "sim_arm");
    add(1, 0, 1, 10, 2, 0, 0, 0, "sim_play");
    add(1, 0, 1, 42, 2, 4, 2, 0, "count_42");
    add(1, 1, 1, 1,  3, 4, 2, 0, "tick_and_press");
    add(0, 0, 0, 1,  0, B, B, 0, "sim_disarm");
    // Expiring tick and press together in READY
    add(0, 0, 1, 1,  1, B, B, 0, "exp_arm");
    add(1, 0, 1, 9,  1, B, B, 0, "exp_9_ticks");
    add(1, 1, 1, 1,  3, 9, 9, 1, "expiry_and_press");
    add(0, 0, 0, 1,  0, B, B, 0, "exp_disarm");
    // Aborts
    add(0, 0, 1, 1,  1, B, B, 0, "ab_arm");
    add(1, 0, 1, 10, 2, 0, 0, 0, "ab_play");
    add(1, 0, 1, 15, 2, 1, 5, 0, "count_15");
    add(1, 0, 0, 1,  0, B, B, 0, "abort_play");
    add(0, 0, 1, 1,  1, B, B, 0, "ab2_arm");
    add(1, 0, 1, 3,  1, B, B, 0, "ab2_ticks");
    add(0, 1, 0, 1,  0, B, B, 0, "abort_ready_with_press");
    // Press in START ignored; button held across arm is not a press
    add(0, 0, 0, 1,  0, B, B, 0, "start_release");
    add(0, 1, 0, 2,  0, B, B, 0, "start_press_ignored");
    add(0, 1, 1, 1,  1, B, B, 0, "arm_btn_held");
    add(1, 1, 1, 9,  1, B, B, 0, "held_not_press");
    add(1, 1, 1, 1,  2, 0, 0, 0, "held_play");
    add(0, 0, 0, 1,  0, B, B, 0, "held_disarm");

    // Reset
    rst_n = 1'b0;
    repeat (3) cyc(0, 0, 1);
    chk("reset", 0, B, B, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) cyc(vecs[i].tick, vecs[i].btn, vecs[i].arm);
      chk(vecs[i].name, vecs[i].st, vecs[i].tens, vecs[i].ones, vecs[i].fs);
    end

    // Mid-game reset in READY, then re-arm with the button held through reset release
    cyc(0, 0, 1);
    repeat (3) cyc(1, 0, 1);
    chk("mid_ready", 1, B, B, 0);
    rst_n = 1'b0;
    cyc(1, 1, 1);
    chk("rst_mid_ready", 0, B, B, 0);
    cyc(0, 1, 1);
    rst_n = 1'b1;
    cyc(0, 1, 1);
    chk("rearm_after_rst", 1, B, B, 0);
    repeat (9) cyc(1, 1, 1);
    chk("rearm_held_btn", 1, B, B, 0);
    cyc(1, 1, 1);
    chk("rearm_full_delay", 2, 0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    chk("rearm_press", 3, 0, 0, 0);
    rst_n = 1'b0;
    cyc(0, 0, 1);
    chk("rst_in_finish", 0, B, B, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // Random delay: MIN_DELAY=2, RAND_W=3 -> 2 + lfsr[2:0] ticks
    for (int g = 0; g < 4; g++) begin
      int exp_d;
      int n;
      repeat (g * 3 + 1) begin
        @(posedge clk);
        #1;
      end
      exp_d = 2 + int'(m_lfsr & 8'h07);
      arm2 = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (state2 != 2'd2 && n < 20) begin
        tick2 = 1'b1;
        @(posedge clk);
        #1;
        tick2 = 1'b0;
        n++;
      end
      total++;
      if (state2 != 2'd2 || n != exp_d || tens2 != 4'd0 || ones2 != 4'd0) begin
        bad++;
        $display("FAIL rand_delay_%0d: got ticks=%0d state=%0d digits=%h%h, want ticks=%0d state=2 digits=00",
                 g, n, state2, tens2, ones2, exp_d);
      end
      arm2 = 1'b0;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
